// File: rtl/game_pkg.sv
// game_pkg: shared state encodings, obstacle colour and health width for the game pixel pipeline.
package game_pkg;
    localparam int HP_W = 7;
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] COOLDOWN = 2'd2;
    localparam logic [1:0] DEAD     = 2'd3;
    localparam logic [11:0] OBSTACLE_RGB = 12'hFFF;
endpackage

// File: rtl/frame_tick_det.sv
// frame_tick_det: one-cycle tick on the rising edge of vblnk, detected against a registered copy.
module frame_tick_det (
    input  logic pclk,
    input  logic rst,
    input  logic vblnk,
    output logic tick
);
    logic vblnk_q;
    always_ff @(posedge pclk) vblnk_q <= rst ? 1'b0 : vblnk;
    assign tick = vblnk & ~vblnk_q;
endmodule

// File: rtl/player_hit_ctl.sv
// player_hit_ctl: per-frame player/obstacle collision, damage, invulnerability window and health.
// Optional damage blink on the hitbox during cooldown when PLAYER_HIT_FLASH_EN is defined.
module player_hit_ctl
    import game_pkg::HP_W, game_pkg::IDLE, game_pkg::ARMED, game_pkg::COOLDOWN, game_pkg::DEAD;
#(
    parameter int HP_MAX        = 100,
    parameter int DAMAGE        = 10,
    parameter int INVULN_FRAMES = 60,
    parameter int PLAYER_SIZE   = 16,
`ifdef PLAYER_HIT_FLASH_EN
    parameter logic [11:0] DAMAGE_RGB = 12'hF00,
`endif
    parameter logic [11:0] OBSTACLE_RGB = game_pkg::OBSTACLE_RGB
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic [11:0]     hcount_in,
    input  logic [11:0]     vcount_in,
    input  logic            vblnk_in,
    input  logic [11:0]     rgb_in,
    input  logic [11:0]     player_x,
    input  logic [11:0]     player_y,
    input  logic            game_on,
    output logic [11:0]     hcount_out,
    output logic [11:0]     vcount_out,
    output logic            vblnk_out,
    output logic [11:0]     rgb_out,
    output logic [HP_W-1:0] health,
    output logic            hit,
    output logic            invulnerable,
    output logic            game_over
);
    logic [1:0]      state;
    logic [7:0]      frame_cnt;
    logic            coll_seen;
    logic            tick;
    logic            in_box;
    logic            overlap;
    logic [12:0]     x_end;
    logic [12:0]     y_end;
    logic [HP_W-1:0] hp_dec;
    logic [11:0]     rgb_nxt;

    frame_tick_det u_tick (.pclk(pclk), .rst(rst), .vblnk(vblnk_in), .tick(tick));

    // 13-bit edges keep a hitbox touching the counter limit from wrapping to zero
    assign x_end   = {1'b0, player_x} + 13'(PLAYER_SIZE - 1);
    assign y_end   = {1'b0, player_y} + 13'(PLAYER_SIZE - 1);
    assign in_box  = hcount_in >= player_x && {1'b0, hcount_in} <= x_end &&
                     vcount_in >= player_y && {1'b0, vcount_in} <= y_end;
    assign overlap = in_box && rgb_in == OBSTACLE_RGB && !vblnk_in;
    assign hp_dec  = health > HP_W'(DAMAGE) ? health - HP_W'(DAMAGE) : '0;

    assign invulnerable = state == COOLDOWN;
    assign game_over    = state == DEAD;

`ifdef PLAYER_HIT_FLASH_EN
    assign rgb_nxt = (state == COOLDOWN && frame_cnt[3] && in_box && rgb_in != OBSTACLE_RGB) ?
                     DAMAGE_RGB : rgb_in;
`else
    assign rgb_nxt = rgb_in;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_nxt;
        end
    end

    // Dropping game_on outranks a same-cycle tick, so no damage lands on the way out
    always_ff @(posedge pclk) begin
        if (rst || !game_on) begin
            state     <= IDLE;
            health    <= HP_W'(HP_MAX);
            frame_cnt <= '0;
            coll_seen <= 1'b0;
            hit       <= 1'b0;
        end else begin
            hit       <= 1'b0;
            coll_seen <= tick ? 1'b0 : coll_seen | overlap;
            case (state)
                IDLE: begin
                    state  <= ARMED;
                    health <= HP_W'(HP_MAX);
                end
                ARMED: if (tick && coll_seen) begin
                    health    <= hp_dec;
                    hit       <= 1'b1;
                    state     <= hp_dec == '0 ? DEAD : COOLDOWN;
                    frame_cnt <= 8'(INVULN_FRAMES - 1);
                end
                COOLDOWN: if (tick) begin
                    if (frame_cnt == '0) state <= ARMED;
                    else frame_cnt <= frame_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_player_hit_ctl.sv
// tb_player_hit_ctl: directed frames against player_hit_ctl, plus a low-HP instance for saturation.
module tb_player_hit_ctl;
    import game_pkg::*;

    logic        pclk = 1'b0;
    logic        rst, vblnk_in, game_on;
    logic [11:0] hcount_in, vcount_in, rgb_in, player_x, player_y;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        vblnk_out, hit, invulnerable, game_over;
    logic [6:0]  health;
    logic [11:0] hcount_out_s, vcount_out_s, rgb_out_s;
    logic        vblnk_out_s, hit_s, invulnerable_s, game_over_s;
    logic [6:0]  health_s;

    int   checks = 0;
    int   errors = 0;
    int   hits;
    logic last_hit;

    player_hit_ctl dut (
        .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .vblnk_in(vblnk_in), .rgb_in(rgb_in), .player_x(player_x), .player_y(player_y),
        .game_on(game_on), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .vblnk_out(vblnk_out), .rgb_out(rgb_out), .health(health), .hit(hit),
        .invulnerable(invulnerable), .game_over(game_over)
    );

    player_hit_ctl #(.HP_MAX(5)) dut_s (
        .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .vblnk_in(vblnk_in), .rgb_in(rgb_in), .player_x(player_x), .player_y(player_y),
        .game_on(game_on), .hcount_out(hcount_out_s), .vcount_out(vcount_out_s),
        .vblnk_out(vblnk_out_s), .rgb_out(rgb_out_s), .health(health_s), .hit(hit_s),
        .invulnerable(invulnerable_s), .game_over(game_over_s)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active pixel, then the vblnk rise; hit/health are sampled the cycle after the tick
    task automatic frame_px(input logic [11:0] h, input logic [11:0] v, input logic [11:0] rgb);
        @(negedge pclk);
        vblnk_in = 1'b0; hcount_in = h; vcount_in = v; rgb_in = rgb;
        @(negedge pclk);
        vblnk_in = 1'b1; rgb_in = 12'hFFF; hcount_in = player_x + 12'd3; vcount_in = player_y + 12'd3;
        @(negedge pclk);
        last_hit = hit;
        hits += int'(hit);
    endtask

    task automatic frame(input logic ov);
        frame_px(player_x + 12'd3, player_y + 12'd3, ov ? 12'hFFF : 12'h000);
    endtask

    task automatic restart();
        @(negedge pclk); game_on = 1'b0;
        @(negedge pclk); game_on = 1'b1;
        @(negedge pclk);
    endtask

    initial begin
        rst = 1'b1; game_on = 1'b0; vblnk_in = 1'b0;
        hcount_in = 12'd7; vcount_in = 12'd9; rgb_in = 12'h123;
        player_x = 12'd100; player_y = 12'd200;
        hits = 0; last_hit = 1'b0;
        repeat (2) @(negedge pclk);
        check("rst_health", health, 100);
        check("rst_hit", hit, 0);
        check("rst_invuln", invulnerable, 0);
        check("rst_game_over", game_over, 0);
        check("rst_rgb_out", rgb_out, 0);
        check("rst_hcount_out", hcount_out, 0);
        check("rst_health_s", health_s, 5);

        rst = 1'b0; game_on = 1'b1;
        @(negedge pclk);
        check("start_state", dut.state, ARMED);
        check("start_health", health, 100);
        check("start_hcount_out", hcount_out, 7);
        check("start_rgb_out", rgb_out, 12'h123);

        hcount_in = 12'd123; vcount_in = 12'd45; rgb_in = 12'hABC; vblnk_in = 1'b1;
        @(negedge pclk);
        check("pipe_hcount", hcount_out, 123);
        check("pipe_vcount", vcount_out, 45);
        check("pipe_vblnk", vblnk_out, 1);
        check("pipe_rgb", rgb_out, 12'hABC);

        frame(1'b0);
        check("black_in_box_hit", last_hit, 0);
        frame_px(player_x - 12'd1, player_y + 12'd3, 12'hFFF);
        check("left_edge_hit", last_hit, 0);
        frame_px(player_x + 12'd16, player_y + 12'd3, 12'hFFF);
        check("right_edge_hit", last_hit, 0);
        frame_px(player_x + 12'd3, player_y - 12'd1, 12'hFFF);
        check("top_edge_hit", last_hit, 0);
        frame_px(player_x + 12'd3, player_y + 12'd16, 12'hFFF);
        check("bottom_edge_hit", last_hit, 0);
        check("no_hit_health", health, 100);
        check("no_hit_health_s", health_s, 5);

        frame(1'b1);
        check("hit1_pulse", last_hit, 1);
        check("hit1_health", health, 90);
        check("hit1_invuln", invulnerable, 1);
        check("sat_health_s", health_s, 0);
        check("sat_hit_s", last_hit, 1);
        check("sat_game_over_s", game_over_s, 1);
        check("sat_state_s", dut_s.state, DEAD);
        @(negedge pclk);
        check("hit1_pulse_width", hit, 0);

        hits = 0;
        repeat (59) frame(1'b1);
        check("cool59_invuln", invulnerable, 1);
        frame(1'b1);
        check("cool60_invuln", invulnerable, 0);
        check("cool_hits", hits, 0);
        check("cool_health", health, 90);
        frame(1'b1);
        check("hit2_pulse", last_hit, 1);
        check("hit2_health", health, 80);

        for (int i = 0; i < 8; i++) begin
            hits = 0;
            repeat (61) frame(1'b1);
            check($sformatf("loop%0d_hits", i), hits, 1);
            check($sformatf("loop%0d_health", i), health, 70 - 10 * i);
        end
        check("dead_game_over", game_over, 1);
        check("dead_invuln", invulnerable, 0);
        check("dead_state", dut.state, DEAD);
        hits = 0;
        repeat (3) frame(1'b1);
        check("dead_hits", hits, 0);
        check("dead_health", health, 0);
        check("dead_game_over_hold", game_over, 1);
        check("dead_game_over_s", game_over_s, 1);

        restart();
        check("restart_health", health, 100);
        check("restart_game_over", game_over, 0);
        check("restart_state", dut.state, ARMED);

        @(negedge pclk);
        vblnk_in = 1'b0; hcount_in = player_x + 12'd3; vcount_in = player_y + 12'd3; rgb_in = 12'hFFF;
        @(negedge pclk);
        vblnk_in = 1'b1; game_on = 1'b0;
        @(negedge pclk);
        check("drop_armed_hit", hit, 0);
        check("drop_armed_health", health, 100);
        check("drop_armed_state", dut.state, IDLE);
        game_on = 1'b1;
        @(negedge pclk);
        frame(1'b0);
        check("drop_flag_cleared", last_hit, 0);

        frame(1'b1);
        check("hit3_health", health, 90);
        frame(1'b1);
        check("cool_mid_invuln", invulnerable, 1);
        @(negedge pclk);
        vblnk_in = 1'b0; hcount_in = player_x + 12'd3; vcount_in = player_y + 12'd3; rgb_in = 12'hFFF;
        @(negedge pclk);
        vblnk_in = 1'b1; game_on = 1'b0;
        @(negedge pclk);
        check("drop_cool_state", dut.state, IDLE);
        check("drop_cool_health", health, 100);
        check("drop_cool_invuln", invulnerable, 0);
        check("drop_cool_hit", hit, 0);
        game_on = 1'b1;
        @(negedge pclk);

        player_x = 12'd630; player_y = 12'd10;
        frame_px(12'd0, 12'd12, 12'hFFF);
        check("x630_h0_hit", last_hit, 0);
        player_x = 12'd4090;
        frame_px(12'd2, 12'd12, 12'hFFF);
        check("x4090_h2_hit", last_hit, 0);
        frame_px(12'd4095, 12'd12, 12'hFFF);
        check("x4090_h4095_hit", last_hit, 1);
        check("x4090_health", health, 90);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
